// File: rtl/conv_pkg.sv
// Shared constants and types for the convolution partial-sum accumulator.
package conv_pkg;

  localparam int unsigned COLUMN_NUM     = 16;
  localparam int unsigned PIXEL_WIDTH_88 = 24;
  localparam int unsigned PIXEL_WIDTH_18 = 16;
  localparam int unsigned LANES_88       = COLUMN_NUM * 2 * 1;
  localparam int unsigned LANES_18       = COLUMN_NUM * 2 * 2;
  localparam int unsigned IN_WIDTH       = PIXEL_WIDTH_18 * LANES_18;
  localparam int unsigned ACC_WIDTH      = 32;
  localparam int unsigned OUT_WIDTH      = LANES_18 * ACC_WIDTH;

  typedef enum logic {
    MODE_88 = 1'b0,
    MODE_18 = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_HOLD,
    ST_DRAIN
  } state_e;

endpackage

// File: rtl/conv_psum_accum_if.sv
// PE-bus input stream and result output stream of the partial-sum accumulator.
interface conv_psum_accum_if
  import conv_pkg::*;
#(
  parameter int unsigned in_width  = IN_WIDTH,
  parameter int unsigned out_width = OUT_WIDTH
);
  logic                 in_valid;
  logic                 in_ready;
  logic [in_width-1:0]  in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [out_width-1:0] out_data;
  logic                 out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/psum_lane_extend.sv
// Unpacks the PE bus into signed lanes and sign-extends each to accumulator width.
module psum_lane_extend
  import conv_pkg::*;
#(
  parameter int unsigned lanes_88       = LANES_88,
  parameter int unsigned lanes_18       = LANES_18,
  parameter int unsigned pixel_width_88 = PIXEL_WIDTH_88,
  parameter int unsigned pixel_width_18 = PIXEL_WIDTH_18,
  parameter int unsigned in_width       = IN_WIDTH,
  parameter int unsigned acc_width      = ACC_WIDTH
) (
  input  mode_e                                mode,
  input  logic [in_width-1:0]                  in_data,
  output logic [lanes_18-1:0][acc_width-1:0]   ext
);

  // Mode 0 leaves the upper lanes at zero so they never accumulate.
  always_comb begin
    ext = '0;
    if (mode == MODE_18) begin
      for (int unsigned i = 0; i < lanes_18; i++)
        ext[i] = acc_width'($signed(in_data[i*pixel_width_18 +: pixel_width_18]));
    end else begin
      for (int unsigned i = 0; i < lanes_88; i++)
        ext[i] = acc_width'($signed(in_data[i*pixel_width_88 +: pixel_width_88]));
    end
  end

endmodule

// File: rtl/conv_psum_accum.sv
// Accumulates PE partial-sum beats per pass and hands each pass result to a one-deep output slot.
module conv_psum_accum
  import conv_pkg::*;
#(
  parameter int unsigned column_num     = COLUMN_NUM,
  parameter int unsigned pixel_width_88 = PIXEL_WIDTH_88,
  parameter int unsigned pixel_width_18 = PIXEL_WIDTH_18,
  parameter int unsigned lanes_88       = column_num * 2 * 1,
  parameter int unsigned lanes_18       = column_num * 2 * 2,
  parameter int unsigned in_width       = pixel_width_18 * lanes_18,
  parameter int unsigned acc_width      = ACC_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    mode,
  input  logic [31:0]             nif_mult_k_mult_k,
  input  logic [15:0]             num_passes,
  conv_psum_accum_if.slave        bus,
  output logic                    busy,
  output logic                    done
);

  typedef logic [lanes_18-1:0][acc_width-1:0] lanes_t;

  state_e      state_q, state_d;
  mode_e       mode_q, mode_d;
  logic [31:0] nkk_q, nkk_d;
  logic [15:0] passes_q, passes_d;
  logic [31:0] beat_q, beat_d;
  logic [15:0] pass_q, pass_d;
  lanes_t      acc_q, acc_d;
  lanes_t      slot_q, slot_d;
  logic        out_valid_q, out_valid_d;
  logic        out_last_q, out_last_d;
  logic        in_ready_q, in_ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  lanes_t      ext;
  lanes_t      sum;
  lanes_t      xfer_src;
  logic        xfer;
  logic        accept, slot_free, last_beat, final_pass;

  psum_lane_extend #(
    .lanes_88       (lanes_88),
    .lanes_18       (lanes_18),
    .pixel_width_88 (pixel_width_88),
    .pixel_width_18 (pixel_width_18),
    .in_width       (in_width),
    .acc_width      (acc_width)
  ) u_extend (
    .mode    (mode_q),
    .in_data (bus.in_data),
    .ext     (ext)
  );

  assign accept     = bus.in_valid && in_ready_q;
  assign slot_free  = !out_valid_q || bus.out_ready;
  assign last_beat  = (beat_q == nkk_q - 32'd1);
  assign final_pass = (pass_q == passes_q - 16'd1);

  // Next-state: FSM, accumulation, slot load/drain.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    nkk_d       = nkk_q;
    passes_d    = passes_q;
    beat_d      = beat_q;
    pass_d      = pass_q;
    acc_d       = acc_q;
    slot_d      = slot_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    xfer        = 1'b0;
    xfer_src    = acc_q;

    for (int unsigned i = 0; i < lanes_18; i++)
      sum[i] = acc_q[i] + ext[i];

    if (out_valid_q && bus.out_ready)
      out_valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d     = mode_e'(mode);
          nkk_d      = (nif_mult_k_mult_k == '0) ? 32'd1 : nif_mult_k_mult_k;
          passes_d   = (num_passes == '0) ? 16'd1 : num_passes;
          acc_d      = '0;
          beat_d     = '0;
          pass_d     = '0;
          out_last_d = 1'b0;
          state_d    = ST_ACC;
        end
      end
      ST_ACC: begin
        if (accept) begin
          if (last_beat) begin
            beat_d = '0;
            if (slot_free) begin
              xfer     = 1'b1;
              xfer_src = sum;
            end else begin
              acc_d   = sum;
              state_d = ST_HOLD;
            end
          end else begin
            acc_d  = sum;
            beat_d = beat_q + 32'd1;
          end
        end
      end
      ST_HOLD: begin
        if (slot_free)
          xfer = 1'b1;
      end
      ST_DRAIN: begin
        if (out_valid_q && bus.out_ready) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Slot transfer is shared by ACC (fresh sum) and HOLD (parked sum).
    if (xfer) begin
      slot_d      = xfer_src;
      acc_d       = '0;
      out_valid_d = 1'b1;
      out_last_d  = final_pass;
      pass_d      = pass_q + 16'd1;
      state_d     = final_pass ? ST_DRAIN : ST_ACC;
    end

    in_ready_d = (state_d == ST_ACC);
    busy_d     = (state_d != ST_IDLE);
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_88;
      nkk_q       <= '0;
      passes_q    <= '0;
      beat_q      <= '0;
      pass_q      <= '0;
      acc_q       <= '0;
      slot_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      nkk_q       <= nkk_d;
      passes_q    <= passes_d;
      beat_q      <= beat_d;
      pass_q      <= pass_d;
      acc_q       <= acc_d;
      slot_q      <= slot_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = slot_q;
  assign bus.out_last  = out_last_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_conv_psum_accum.sv
// Self-checking bench: behavioural per-pass lane-sum model plus directed literal checks.
module tb_conv_psum_accum;
  import conv_pkg::*;

  typedef struct packed {
    logic                              last;
    logic [LANES_18-1:0][ACC_WIDTH-1:0] data;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        mode;
  logic [31:0] nkk;
  logic [15:0] passes;
  logic        busy, done;

  conv_psum_accum_if bus ();

  conv_psum_accum dut (
    .clk               (clk),
    .reset             (rst_n),
    .start             (start),
    .mode              (mode),
    .nif_mult_k_mult_k (nkk),
    .num_passes        (passes),
    .bus               (bus),
    .busy              (busy),
    .done              (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  logic                              m_mode;
  int                                m_nkk, m_passes, m_beats, m_pass;
  logic [LANES_18-1:0][ACC_WIDTH-1:0] m_acc;
  res_t                              exp_q[$];
  logic                              done_pending = 1'b0;
  logic                              rdy_rand = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_data(input string name, input logic [OUT_WIDTH-1:0] act,
                          input logic [OUT_WIDTH-1:0] exp);
    logic [LANES_18-1:0][ACC_WIDTH-1:0] a, e;
    a = act; e = exp;
    n_checks++;
    if (a !== e) begin
      n_fail++;
      for (int i = 0; i < LANES_18; i++)
        if (a[i] !== e[i]) begin
          $display("FAIL %s: lane %0d got %h expected %h", name, i, a[i], e[i]);
          break;
        end
    end
  endtask

  // Sign-extended lane value of a beat, from the lane-format rules.
  function automatic int lane_val(input logic md, input logic [IN_WIDTH-1:0] d, input int i);
    logic signed [15:0] v16;
    logic signed [23:0] v24;
    if (md) begin
      v16 = d[i*16 +: 16];
      return int'(v16);
    end
    if (i >= 32) return 0;
    v24 = d[i*24 +: 24];
    return int'(v24);
  endfunction

  // Model update on accepted beats and checking on every output handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      done_pending = 1'b0;
    end else begin
      chk("done_pulse", {31'd0, done}, {31'd0, done_pending});
      if (done_pending) chk("busy_after_done", {31'd0, busy}, 32'd0);
      done_pending = 1'b0;
      if (bus.in_valid && bus.in_ready) begin
        for (int i = 0; i < LANES_18; i++)
          m_acc[i] = m_acc[i] + 32'(lane_val(m_mode, bus.in_data, i));
        m_beats++;
        if (m_beats == m_nkk) begin
          exp_q.push_back('{last: (m_pass + 1 == m_passes), data: m_acc});
          m_acc = '0;
          m_beats = 0;
          m_pass++;
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          res_t r;
          r = exp_q.pop_front();
          chk_data("result_data", bus.out_data, r.data);
          chk("result_last", {31'd0, bus.out_last}, {31'd0, r.last});
          if (r.last) done_pending = 1'b1;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rdy_rand) bus.out_ready = 1'($urandom_range(0, 1));
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic md, input int k, input int p);
    start = 1'b1; mode = md; nkk = k; passes = 16'(p);
    m_mode = md;
    m_nkk = (k == 0) ? 1 : k;
    m_passes = (p == 0) ? 1 : p;
    m_beats = 0; m_pass = 0; m_acc = '0;
    tick();
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [IN_WIDTH-1:0] d);
    logic acc;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = d;
    for (int n = 0; n < 300 && !acc; n++) begin
      @(negedge clk);
      acc = bus.in_ready;
      tick();
    end
    if (!acc) chk("beat_accept_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 1000 && !seen; n++) begin
      @(negedge clk);
      seen = done;
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
    tick();
  endtask

  function automatic logic [IN_WIDTH-1:0] rand_data();
    logic [IN_WIDTH-1:0] d;
    for (int w = 0; w < IN_WIDTH / 32; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  logic [LANES_18-1:0][ACC_WIDTH-1:0] od;
  logic [IN_WIDTH-1:0]                beat_a, beat_b;

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; nkk = '0; passes = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    m_acc = '0; m_nkk = 1; m_passes = 1; m_beats = 0; m_pass = 0; m_mode = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_out_data_or", {31'd0, |bus.out_data}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Mode 1, 8 beats of lane value 3
    do_start(1'b1, 8, 1);
    @(negedge clk);
    chk("t1_in_ready_after_start", {31'd0, bus.in_ready}, 32'd1);
    tick();
    for (int b = 0; b < 8; b++) send_beat({64{16'h0003}});
    @(negedge clk);
    od = bus.out_data;
    chk("t1_out_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("t1_lane0", od[0], 32'd24);
    chk("t1_lane63", od[63], 32'd24);
    chk("t1_out_last", {31'd0, bus.out_last}, 32'd1);
    tick();
    wait_done();

    // Mode 0, four beats of -1; upper lanes zero-filled
    bus.out_ready = 1'b0;
    do_start(1'b0, 4, 1);
    for (int b = 0; b < 4; b++) send_beat({256'h0, {32{24'hFFFFFF}}});
    @(negedge clk);
    od = bus.out_data;
    chk("t2_lane0", od[0], 32'hFFFFFFFC);
    chk("t2_lane31", od[31], 32'hFFFFFFFC);
    chk("t2_lane32", od[32], 32'h0);
    chk("t2_lane63", od[63], 32'h0);
    tick();
    bus.out_ready = 1'b1;
    wait_done();

    // Three passes with a stalled slot forcing HOLD
    bus.out_ready = 1'b0;
    do_start(1'b1, 2, 3);
    for (int b = 0; b < 4; b++) send_beat(rand_data());
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t3_hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("t3_hold_out_valid", {31'd0, bus.out_valid}, 32'd1);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("t3_resume_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("t3_second_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("t3_second_not_last", {31'd0, bus.out_last}, 32'd0);
    tick();
    for (int b = 0; b < 2; b++) send_beat(rand_data());
    wait_done();

    // Drain and transfer in the same cycle
    bus.out_ready = 1'b0;
    do_start(1'b1, 2, 2);
    send_beat(rand_data());
    send_beat(rand_data());
    send_beat(rand_data());
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = rand_data();
    @(negedge clk);
    chk("t4_in_ready_on_last", {31'd0, bus.in_ready}, 32'd1);
    chk("t4_valid_before", {31'd0, bus.out_valid}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t4_valid_back_to_back", {31'd0, bus.out_valid}, 32'd1);
    chk("t4_last", {31'd0, bus.out_last}, 32'd1);
    chk("t4_drain_in_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    wait_done();

    // Zero config values and start-while-busy
    do_start(1'b1, 0, 0);
    start = 1'b1; mode = 1'b0; nkk = 32'd7; passes = 16'd9;
    tick();
    start = 1'b0;
    send_beat(rand_data());
    @(negedge clk);
    chk("t5_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("t5_last", {31'd0, bus.out_last}, 32'd1);
    tick();
    wait_done();

    // Reset mid-job, then a fresh job
    do_start(1'b1, 8, 1);
    for (int b = 0; b < 3; b++) send_beat(rand_data());
    rst_n = 1'b0;
    #2;
    chk("t6_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("t6_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("t6_out_last", {31'd0, bus.out_last}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_done", {31'd0, done}, 32'd0);
    chk("t6_data_or", {31'd0, |bus.out_data}, 32'd0);
    exp_q.delete();
    m_acc = '0; m_beats = 0; m_pass = 0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    do_start(1'b0, 2, 1);
    beat_a = {256'h0, {32{24'h000005}}};
    beat_b = {256'h0, {32{24'h800000}}};
    send_beat(beat_a);
    send_beat(beat_b);
    @(negedge clk);
    od = bus.out_data;
    chk("t6_fresh_lane0", od[0], 32'hFF800005);
    chk("t6_fresh_lane40", od[40], 32'h0);
    tick();
    wait_done();

    // Randomized jobs with random gaps and backpressure
    rdy_rand = 1'b1;
    for (int j = 0; j < 8; j++) begin
      int k, p;
      logic md;
      k = $urandom_range(0, 4);
      p = $urandom_range(0, 3);
      md = 1'($urandom_range(0, 1));
      do_start(md, k, p);
      for (int b = 0; b < ((k == 0) ? 1 : k) * ((p == 0) ? 1 : p); b++) begin
        repeat ($urandom_range(0, 2)) tick();
        send_beat(rand_data());
      end
      wait_done();
    end
    rdy_rand = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/conv_psum_accum.md
# conv_psum_accum

Output-side partner of `conv_datapath_front`: consumes one row/channel-set bus of PE partial sums, sign-extends and accumulates the lanes over `nif_mult_k_mult_k` input beats, then hands each finished output-pixel group to the output buffer over a valid/ready port. One instance sits on each `out_rowR_channel_setC` bus, 12 per datapath. It supports multiple passes per start and holds a finished result in a one-deep slot, so accumulation of the next pass can begin while the previous result drains.

## Interface
Parameters:
- `column_num`, 16, PE columns per bus
- `pixel_width_88`, 24, lane width in mode 0 (8x8)
- `pixel_width_18`, 16, lane width in mode 1 (1x8)
- `lanes_88`, 32, `column_num*2*1`
- `lanes_18`, 64, `column_num*2*2`
- `in_width`, 1024, `pixel_width_18*lanes_18`
- `acc_width`, 32, accumulator lane width

Ports:
- `clk`  in  1  clock, all state on the rising edge
- `reset`  in  1  asynchronous, active-low; clears all state
- `start`  in  1  one-cycle job start
- `mode`  in  1  0 = 8x8 lanes, 1 = 1x8 lanes; latched at `start`
- `nif_mult_k_mult_k`  in  32  beats per pass; latched at `start`
- `num_passes`  in  16  passes per job; latched at `start`
- `in_valid`  in  1  PE bus beat valid
- `in_ready`  out  1  beat accepted when `in_valid && in_ready`
- `in_data`  in  `in_width`  PE bus; mode 0 uses bits [767:0]
- `out_valid`  out  1  result slot full
- `out_ready`  in  1  downstream accepts
- `out_data`  out  `lanes_18*acc_width`  lane i at [i*acc_width +: acc_width]; mode 0 zero-fills lanes 32..63
- `out_last`  out  1  result belongs to the final pass
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle pulse when the final result is accepted downstream

## Operation
- Lane unpack: mode 0 splits into 32 signed 24-bit lanes, mode 1 into 64 signed 16-bit lanes. Each lane is sign-extended to `acc_width` and added. Accumulation wraps modulo 2^acc_width, with no saturation.
- FSM states IDLE, ACC, HOLD, DRAIN:
  - IDLE: `in_ready`=0. On `start`, latch config, clear the accumulators, beat count and pass count, then go to ACC.
  - ACC: `in_ready`=1 and each accepted beat adds to the accumulators.
    - On the last beat of a pass, the sum includes that beat. If the slot is free (`!out_valid || out_ready`), the sum moves into the slot, the accumulators clear and the pass count increments. The FSM then goes to ACC if passes remain, otherwise to DRAIN.
    - If the slot is not free, the FSM goes to HOLD with the sum kept in the accumulators.
  - HOLD: `in_ready`=0. When the slot frees, transfer as above.
  - DRAIN: wait for the final slot handshake, pulse `done`, then go to IDLE.
- A `nif_mult_k_mult_k` of 0 is treated as 1. A `num_passes` of 0 is treated as 1.
- `start` while `busy` is ignored and does not change the latched config.
- `out_last` is set on the transfer of the final pass.

## Timing
- Reset values:
  - `in_ready`, `out_valid`, `out_last`, `busy` and `done` are 0.
  - `out_data`, the accumulators and the counters are 0.
  - State is IDLE.
- `start` at cycle t gives `in_ready`=1 at t+1.
- Last beat accepted at cycle n with the slot free gives `out_valid`=1 at n+1. `in_ready` stays 1, so the next pass's first beat may be accepted at n+1.
- The slot is registered and holds steady while `out_valid && !out_ready`. Simultaneous drain and transfer in one cycle keeps `out_valid`=1 and loads the new data.
- `done` asserts the cycle after the final `out_valid && out_ready`, and `busy` drops the same cycle.
- Asserting `reset` mid-job aborts it: outputs return to reset values and no `done` is produced.

## Structure
- Shared package `conv_pkg` holds:
  - the mode encoding (`MODE_88`=0, `MODE_18`=1)
  - the lane-count and lane-width constants
  - the FSM state typedef
- One sub-module, `psum_lane_extend`: combinational unpack plus sign-extend of `in_data` into `lanes_18` lanes of `acc_width` bits, selected by `mode`.

## Test plan
- Mode 1, nkk=8, passes=1: 8 beats with every 16-bit lane = 0x0003. Expect `out_valid` 1 cycle after the 8th beat, every lane = 24, `out_last`=1, `done` after the handshake.
- Mode 0, nkk=4: lanes = 0xFFFFFF (-1). Expect lanes 0..31 = 0xFFFFFFFC and lanes 32..63 = 0.
- passes=3, nkk=2, `out_ready` held 0 after the first result. Expect HOLD with `in_ready`=0 until `out_ready` rises, then results 2 and 3 in order and `out_last` only on the 3rd.
- Simultaneous drain and transfer: `out_ready`=1 on the cycle the next pass's last beat arrives. Expect no HOLD and back-to-back `out_valid`.
- nkk=0, passes=0: one beat yields one final result. A `start` while busy is ignored.
- Assert `reset` after beat 3 of 8. Expect all outputs 0 and IDLE. A new `start` then produces a correct fresh sum.
